// File: rtl/ps_pkg.sv
// Shared program-sequencer definitions: stack status bit positions, ureg codes
// and the push/pop strobe decode used by the PC stack.
package ps_pkg;

    localparam int STK_EMPTY = 0;
    localparam int STK_FULL  = 1;
    localparam int STK_OVF   = 2;
    localparam int STK_UNF   = 3;

    localparam logic [4:0] PS_UREG_PCSTK  = 5'b00100;
    localparam logic [4:0] PS_UREG_PCSTKP = 5'b00101;
    localparam logic [4:0] PS_UREG_STKY   = 5'b11110;

    typedef enum logic [1:0] {
        STK_OP_NONE = 2'b00,
        STK_OP_PUSH = 2'b01,
        STK_OP_POP  = 2'b10,
        STK_OP_SWAP = 2'b11
    } stk_op_e;

    function automatic stk_op_e stk_decode(input logic push, input logic pop);
        return stk_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/ps_stk_flags.sv
// PC stack pointer and status: saturating entry count plus sticky
// overflow/underflow flags.
module ps_stk_flags
    import ps_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  stk_op_e       i_op,
    input  logic          i_stky_clr,
    output logic [PW-1:0] o_pntr,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_ovf,
    output logic          o_unf
);

    logic [PW-1:0] r_pntr;
    logic          r_ovf;
    logic          r_unf;
    logic          w_empty;
    logic          w_full;
    logic          w_set_ovf;
    logic          w_set_unf;

    assign w_empty   = (r_pntr == '0);
    assign w_full    = (r_pntr == PW'(DEPTH));
    assign w_set_ovf = (i_op == STK_OP_PUSH) && w_full;
    assign w_set_unf = (i_op == STK_OP_POP) && w_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pntr <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else begin
            case (i_op)
                STK_OP_PUSH: if (!w_full)  r_pntr <= r_pntr + PW'(1);
                STK_OP_POP:  if (!w_empty) r_pntr <= r_pntr - PW'(1);
                // a combined push/pop on an empty stack degenerates to a push
                STK_OP_SWAP: if (w_empty)  r_pntr <= r_pntr + PW'(1);
                default: ;
            endcase
            r_ovf <= w_set_ovf | (r_ovf & ~i_stky_clr);
            r_unf <= w_set_unf | (r_unf & ~i_stky_clr);
        end
    end

    assign o_pntr  = r_pntr;
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_ovf   = r_ovf;
    assign o_unf   = r_unf;

endmodule

// File: rtl/ps_pc_stack.sv
// Program-sequencer PC stack: DEPTH-entry LIFO of return addresses with
// push, pop, replace-top, ureg top write and sticky status.
module ps_pc_stack
    import ps_pkg::*;
#(
    parameter int AW    = 16,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_dt,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_dt,
    input  logic          stky_clr,
    output logic [AW-1:0] top_dt,
    output logic [PW-1:0] pntr,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          unf,
    output logic [3:0]    stky
);

    localparam int AIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]  r_mem [DEPTH];
    stk_op_e        w_op;
    logic [PW-1:0]  w_top_pntr;
    logic [AIW-1:0] w_top_idx;
    logic [AIW-1:0] w_wr_idx;
    logic [AW-1:0]  w_wr_dt;
    logic           w_we;

    assign w_op = stk_decode(push, pop);

    ps_stk_flags #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_flags (
        .clk        (clk),
        .rst        (rst),
        .i_op       (w_op),
        .i_stky_clr (stky_clr),
        .o_pntr     (pntr),
        .o_empty    (empty),
        .o_full     (full),
        .o_ovf      (ovf),
        .o_unf      (unf)
    );

    assign w_top_pntr = pntr - PW'(1);
    assign w_top_idx  = empty ? '0 : w_top_pntr[AIW-1:0];

    // Empty stack: the top index is 0, so replace-top and ureg write land on mem[0].
    always_comb begin
        w_we     = 1'b0;
        w_wr_idx = w_top_idx;
        w_wr_dt  = push_dt;
        case (w_op)
            STK_OP_PUSH: begin
                w_we     = ~full;
                w_wr_idx = pntr[AIW-1:0];
            end
            STK_OP_SWAP: w_we = 1'b1;
            STK_OP_NONE: begin
                w_we    = wr_en;
                w_wr_dt = wr_dt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_we) begin
            r_mem[w_wr_idx] <= w_wr_dt;
        end
    end

    assign top_dt           = r_mem[w_top_idx];
    assign stky[STK_EMPTY]  = empty;
    assign stky[STK_FULL]   = full;
    assign stky[STK_OVF]    = ovf;
    assign stky[STK_UNF]    = unf;

endmodule

// File: tb/tb_ps_pc_stack.sv
// Scoreboard bench for ps_pc_stack (AW=16, DEPTH=4): directed strobes queue
// the expected post-edge state; a monitor compares on the falling edge.
module tb_ps_pc_stack;

    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int PW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          push;
    logic          pop;
    logic [AW-1:0] push_dt;
    logic          wr_en;
    logic [AW-1:0] wr_dt;
    logic          stky_clr;
    logic [AW-1:0] top_dt;
    logic [PW-1:0] pntr;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          unf;
    logic [3:0]    stky;

    typedef struct {
        int          p;
        logic [15:0] t;
        logic [3:0]  s;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    event ev_chk;

    ps_pc_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .push_dt  (push_dt),
        .wr_en    (wr_en),
        .wr_dt    (wr_dt),
        .stky_clr (stky_clr),
        .top_dt   (top_dt),
        .pntr     (pntr),
        .empty    (empty),
        .full     (full),
        .ovf      (ovf),
        .unf      (unf),
        .stky     (stky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk or ev_chk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (int'(pntr) != e.p) begin
                    errors++;
                    $display("FAIL %s pntr: got %0d expected %0d", e.tag, pntr, e.p);
                end
                checks++;
                if (top_dt !== e.t) begin
                    errors++;
                    $display("FAIL %s top_dt: got %h expected %h", e.tag, top_dt, e.t);
                end
                checks++;
                if (stky !== e.s) begin
                    errors++;
                    $display("FAIL %s stky: got %b expected %b", e.tag, stky, e.s);
                end
                checks++;
                if ({unf, ovf, full, empty} !== e.s) begin
                    errors++;
                    $display("FAIL %s flag ports: got %b expected %b", e.tag,
                             {unf, ovf, full, empty}, e.s);
                end
            end
        end
    end

    task automatic step(input logic ps, input logic pp, input logic [15:0] pd,
                        input logic we, input logic [15:0] wd, input logic sc,
                        input int ep, input logic [15:0] et, input logic [3:0] es,
                        input string tag);
        exp_t e;
        push = ps; pop = pp; push_dt = pd; wr_en = we; wr_dt = wd; stky_clr = sc;
        @(posedge clk);
        #1;
        e.p = ep; e.t = et; e.s = es; e.tag = tag;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        rst = 1'b0;
        push = 1'b0; pop = 1'b0; push_dt = '0; wr_en = 1'b0; wr_dt = '0; stky_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        //    push pop push_dt   wr  wr_dt     clr  pntr top       stky
        step(0, 0, 16'h0000, 0, 16'h0000, 0,   0, 16'h0000, 4'b0001, "reset");
        step(1, 0, 16'h0010, 0, 16'h0000, 0,   1, 16'h0010, 4'b0000, "push1");
        step(1, 0, 16'h0020, 0, 16'h0000, 0,   2, 16'h0020, 4'b0000, "push2");
        step(1, 0, 16'h0030, 0, 16'h0000, 0,   3, 16'h0030, 4'b0000, "push3");
        step(1, 0, 16'h0040, 0, 16'h0000, 0,   4, 16'h0040, 4'b0010, "push4_full");
        step(1, 0, 16'h0050, 0, 16'h0000, 0,   4, 16'h0040, 4'b0110, "push_ovf");
        step(1, 0, 16'h0050, 0, 16'h0000, 1,   4, 16'h0040, 4'b0110, "ovf_set_wins_clr");
        step(0, 0, 16'h0000, 0, 16'h0000, 1,   4, 16'h0040, 4'b0010, "stky_clr");
        step(0, 1, 16'h0000, 0, 16'h0000, 0,   3, 16'h0030, 4'b0000, "pop_to3");
        step(1, 1, 16'h0099, 0, 16'h0000, 0,   3, 16'h0099, 4'b0000, "replace_top");
        step(0, 1, 16'h0000, 0, 16'h0000, 0,   2, 16'h0020, 4'b0000, "pop_to2");
        step(0, 1, 16'h0000, 0, 16'h0000, 0,   1, 16'h0010, 4'b0000, "pop_to1");
        step(0, 1, 16'h0000, 0, 16'h0000, 0,   0, 16'h0010, 4'b0001, "pop_to0");
        step(0, 1, 16'h0000, 0, 16'h0000, 0,   0, 16'h0010, 4'b1001, "pop_unf");
        step(0, 0, 16'h0000, 1, 16'hABCD, 0,   0, 16'hABCD, 4'b1001, "wr_empty");
        step(1, 0, 16'h1111, 1, 16'h2222, 0,   1, 16'h1111, 4'b1000, "push_ignores_wr");
        step(0, 1, 16'h0000, 0, 16'h0000, 0,   0, 16'h1111, 4'b1001, "pop_again");
        step(1, 1, 16'h7777, 0, 16'h0000, 0,   1, 16'h7777, 4'b1000, "swap_empty_push");
        step(0, 0, 16'h0000, 1, 16'h5555, 0,   1, 16'h5555, 4'b1000, "wr_top");
        step(0, 1, 16'h0000, 1, 16'h6666, 0,   0, 16'h5555, 4'b1001, "pop_ignores_wr");
        step(1, 0, 16'h0A0A, 0, 16'h0000, 0,   1, 16'h0A0A, 4'b1000, "push_a");
        step(1, 0, 16'h0B0B, 0, 16'h0000, 0,   2, 16'h0B0B, 4'b1000, "push_b");

        push = 1'b0; pop = 1'b0; wr_en = 1'b0; stky_clr = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        e.p = 0; e.t = 16'h0000; e.s = 4'b0001; e.tag = "async_reset";
        q.push_back(e);
        -> ev_chk;
        #4 rst = 1'b1;

        step(0, 0, 16'h0000, 0, 16'h0000, 0,   0, 16'h0000, 4'b0001, "after_reset");
        push = 1'b0; pop = 1'b0; wr_en = 1'b0; stky_clr = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps_pc_stack.md
# ps_pc_stack

Parametrised program-sequencer PC stack: a DEPTH-entry LIFO of AW-bit return addresses with push, pop, combined pop-push, ureg-style top-of-stack write, and a status word with sticky overflow/underflow flags.
- Replaces the fixed 2-entry stack and hard-wired pointer/sticky logic inside the program sequencer.
- Sits between the sequencer's instruction identification (push/pop strobes, ureg write decode) and the bus-connect read mux (top, pointer, status).

## Interface
Parameters:
- AW, 16, address/data width of each stack entry
- DEPTH, 4, number of entries; legal range 2..16
- PW, $clog2(DEPTH+1), pointer width; derived, not to be overridden

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- push  in  1  push push_dt onto the stack this cycle
- pop  in  1  pop the top entry this cycle
- push_dt  in  AW  data pushed; normally the return address
- wr_en  in  1  ureg write to the current top entry
- wr_dt  in  AW  ureg write data
- stky_clr  in  1  clear the sticky ovf/unf flags
- top_dt  out  AW  current top entry; entry 0 when empty
- pntr  out  PW  number of valid entries
- empty  out  1  pntr==0
- full  out  1  pntr==DEPTH
- ovf  out  1  sticky; push attempted while full
- unf  out  1  sticky; pop attempted while empty
- stky  out  4  {unf, ovf, full, empty}; the sequencer's sticky-register view

## Operation
State:
- mem[0..DEPTH-1], AW bits each; pntr; ovf; unf.
- empty and full are decoded combinationally from pntr.

Reset values:
- pntr=0, empty=1, full=0, ovf=0, unf=0, all entries 0.
- Therefore top_dt=0 and stky=4'b0001.

Per-cycle priority:
- push & !pop & !full: mem[pntr]<=push_dt, pntr+1.
- push & !pop & full: no write, pntr unchanged, ovf<=1.
- pop & !push & !empty: pntr-1. The entry is not cleared.
- pop & !push & empty: pntr unchanged, unf<=1.
- push & pop & !empty: replace top, i.e. mem[pntr-1]<=push_dt; pntr unchanged; no flag change.
- push & pop & empty: behaves as a plain push.
- wr_en alone: mem[pntr-1]<=wr_dt if !empty, otherwise mem[0]<=wr_dt; pntr unchanged.
- wr_en with push or pop: wr_en is ignored.

Sticky flags:
- stky_clr clears ovf and unf.
- A set event in the same cycle as stky_clr wins, so the flag reads 1 next cycle.

Read path:
- top_dt = mem[pntr-1] when pntr!=0, else mem[0].
- There is no internal bypass. The sequencer's bypass mux forwards bus data for same-cycle writes.

Width rules:
- pntr arithmetic is PW-bit unsigned.
- pntr never wraps; it saturates at 0 and DEPTH because of the guards above.

## Timing
- All state updates on posedge clk; rst acts asynchronously.
- Push/pop/write takes effect at the edge: pntr, flags and top_dt show the new state one cycle after the strobe.
- Back-to-back strobes on consecutive cycles are fully supported; throughput is one operation per cycle.
- All outputs are combinational from registered state only; there are no input-to-output combinational paths.
- Reset asserted mid-operation: everything returns to reset values immediately, and pending strobes are lost.

## Structure
- Shared package ps_pkg:
  - Status bit indices STK_EMPTY=0, STK_FULL=1, STK_OVF=2, STK_UNF=3.
  - Sequencer ureg codes PS_UREG_PCSTK=5'b00100, PS_UREG_PCSTKP=5'b00101, PS_UREG_STKY=5'b11110.
- One sub-module: ps_stk_flags, holding the pntr/empty/full/ovf/unf update logic. The storage array and read mux stay in ps_pc_stack.

## Test plan
- Reset, DEPTH=4 → pntr=0, stky=4'b0001, top_dt=0.
- Push 16'h0010, 16'h0020, 16'h0030, 16'h0040 on consecutive cycles → pntr 1,2,3,4; full=1 after the 4th push; top_dt=16'h0040; stky=4'b0010.
- Push 16'h0050 while full → pntr stays 4, ovf=1, top_dt=16'h0040. Then stky_clr together with a 2nd push 16'h0050 → ovf still 1. stky_clr alone → ovf=0.
- From 3 entries with top 16'h0030: push+pop of 16'h0099 → pntr=3, top_dt=16'h0099. Then pop ×3 → empty=1. 4th pop → unf=1, pntr=0.
- Empty stack: wr_en with wr_dt=16'hABCD → mem[0]=16'hABCD, top_dt=16'hABCD, pntr=0. Push 16'h1111 with wr_en=1 and wr_dt=16'h2222 → top_dt=16'h1111, pntr=1.
- Assert rst for one half-cycle with 2 entries present → pntr=0 and ovf=unf=0 immediately, with no clock edge needed.
